// File: rtl/sha256_padder_if.sv
// Message-in / padded-block-out bundle for sha256_padder.
// The padder sits on the slave side; the message source and the hash core use the master side.
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         len_err;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last, len_err
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_padder #(
  parameter int LEN_W = 61
) (
  input logic            wb_clk_i,
  input logic            wb_rst_ni,
  sha256_padder_if.slave bus
);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] PAD   = 2'd1;
  localparam logic [1:0] LEN   = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       resume_state;
  logic [3:0]       idx;
  logic [LEN_W-1:0] byte_cnt;
  logic             first_flag;
  logic             last_flag;
  logic             marker_pending;
  logic             len_err_q;
  logic             active;

  logic [31:0]      blk_buf [16];
  logic             buf_we;
  logic [31:0]      buf_wdata;

  logic             accept;
  logic [2:0]       n_eff;
  logic [2:0]       add_bytes;
  logic [LEN_W:0]   cnt_sum;
  logic [31:0]      last_word;
  logic [63:0]      bit_len;

  assign accept    = bus.in_valid && bus.in_ready;
  assign n_eff     = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
  assign add_bytes = bus.in_last ? n_eff : 3'd4;
  assign cnt_sum   = {1'b0, byte_cnt} + {{(LEN_W-2){1'b0}}, add_bytes};
  assign bit_len   = 64'({byte_cnt, 3'b000});

  // Last word: keep the valid leading bytes and put the 0x80 marker right after them.
  always_comb begin
    case (n_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    buf_we    = 1'b0;
    buf_wdata = '0;
    case (state)
      ACCUM: begin
        buf_we    = accept;
        buf_wdata = bus.in_last ? last_word : bus.in_data;
      end
      PAD: begin
        buf_we    = 1'b1;
        buf_wdata = marker_pending ? 32'h8000_0000 : 32'h0;
      end
      LEN: begin
        buf_we    = 1'b1;
        buf_wdata = (idx == 4'd14) ? bit_len[63:32] : bit_len[31:0];
      end
      default: ;
    endcase
  end

  // Every word of a block is rewritten before EMIT, so the buffer needs no reset.
  always_ff @(posedge wb_clk_i) begin
    if (buf_we) begin
      blk_buf[idx] <= buf_wdata;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state          <= ACCUM;
      resume_state   <= ACCUM;
      idx            <= 4'd0;
      byte_cnt       <= '0;
      first_flag     <= 1'b1;
      last_flag      <= 1'b0;
      marker_pending <= 1'b0;
      len_err_q      <= 1'b0;
      active         <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        ACCUM: begin
          if (accept) begin
            byte_cnt <= cnt_sum[LEN_W-1:0];
            if (cnt_sum[LEN_W]) begin
              len_err_q <= 1'b1;
            end
            if (!bus.in_last) begin
              if (idx == 4'd15) begin
                state        <= EMIT;
                resume_state <= ACCUM;
                last_flag    <= 1'b0;
                idx          <= 4'd0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              marker_pending <= (n_eff == 3'd4);
              if (idx == 4'd15) begin
                state        <= EMIT;
                resume_state <= PAD;
                last_flag    <= 1'b0;
                idx          <= 4'd0;
              end else if (idx == 4'd13 && n_eff != 3'd4) begin
                state <= LEN;
                idx   <= 4'd14;
              end else begin
                state <= PAD;
                idx   <= idx + 4'd1;
              end
            end
          end
        end
        PAD: begin
          marker_pending <= 1'b0;
          // Index 13 is always written with the marker already placed, so words 14/15 are free.
          if (idx == 4'd15) begin
            state        <= EMIT;
            resume_state <= PAD;
            last_flag    <= 1'b0;
            idx          <= 4'd0;
          end else if (idx == 4'd13) begin
            state <= LEN;
            idx   <= 4'd14;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        LEN: begin
          if (idx == 4'd15) begin
            state        <= EMIT;
            resume_state <= ACCUM;
            last_flag    <= 1'b1;
            idx          <= 4'd0;
          end else begin
            idx <= 4'd15;
          end
        end
        default: begin
          if (bus.blk_ready) begin
            state      <= resume_state;
            first_flag <= last_flag;
            if (last_flag) begin
              byte_cnt <= '0;
              idx      <= 4'd0;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = active && (state == ACCUM);
  assign bus.blk_valid = (state == EMIT);
  assign bus.blk_first = (state == EMIT) && first_flag;
  assign bus.blk_last  = (state == EMIT) && last_flag;
  assign bus.len_err   = len_err_q;

  always_comb begin
    bus.blk_data = '0;
    if (state == EMIT) begin
      for (int i = 0; i < 16; i++) begin
        bus.blk_data[511 - 32*i -: 32] = blk_buf[i];
      end
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed and random messages against
// a byte-level SHA-256 padding model, plus reset and length-overflow checks.
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;

  always #5 clk = ~clk;

  sha256_padder_if bus ();
  sha256_padder_if bus4 ();

  sha256_padder dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  sha256_padder #(.LEN_W(4)) dut4 (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst4_n),
    .bus       (bus4)
  );

  int vectors     = 0;
  int miscompares = 0;

  byte unsigned msg [$];
  logic [511:0] exp_blk [$];
  logic         exp_first [$];
  logic         exp_last [$];

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: append 0x80, zero fill to 56 mod 64, then the 64-bit bit length; cut into 64-byte blocks.
  function automatic void buildReference(input byte unsigned m [$]);
    byte unsigned p [$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nb;
    p    = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nb - 1);
    end
  endfunction

  task automatic applyStimulus(input byte unsigned m [$], input int stall);
    int   nwords, lastn, w, stall_left, budget;
    logic [7:0] bt [4];
    buildReference(m);
    nwords     = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
    lastn      = m.size() - 4 * (nwords - 1);
    w          = 0;
    stall_left = stall;
    budget     = 0;
    while (exp_blk.size() > 0 && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (bus.blk_valid) begin
        checkOutput("in_ready_during_emit", bus.in_ready, 1'b0);
        checkOutput("blk_data", bus.blk_data, exp_blk[0]);
        checkOutput("blk_first", bus.blk_first, exp_first[0]);
        checkOutput("blk_last", bus.blk_last, exp_last[0]);
        if (stall_left > 0) begin
          bus.blk_ready = 1'b0;
          stall_left--;
        end else begin
          bus.blk_ready = 1'b1;
          void'(exp_blk.pop_front());
          void'(exp_first.pop_front());
          void'(exp_last.pop_front());
          stall_left = stall;
        end
      end else begin
        bus.blk_ready = 1'($urandom_range(0, 1));
      end
      for (int b = 0; b < 4; b++) begin
        bt[b] = (4*w + b < m.size()) ? m[4*w + b] : 8'($urandom);
      end
      bus.in_data   = {bt[0], bt[1], bt[2], bt[3]};
      bus.in_valid  = (w < nwords) && ($urandom_range(0, 3) != 0);
      bus.in_last   = (w == nwords - 1);
      if (w == nwords - 1) begin
        bus.in_nbytes = (lastn == 4) ? 3'($urandom_range(4, 7)) : 3'(lastn);
      end else begin
        bus.in_nbytes = 3'($urandom_range(0, 7));
      end
      if (bus.in_valid && bus.in_ready) w++;
    end
    checkOutput("blocks_outstanding", exp_blk.size(), 0);
    checkOutput("words_consumed", w, nwords);
    exp_blk.delete();
    exp_first.delete();
    exp_last.delete();
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;
  endtask

  task automatic randomMsg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  initial begin
    int w;
    int budget;
    int lens [10] = '{1, 4, 52, 53, 55, 57, 60, 61, 119, 120};

    rst_n          = 1'b0;
    rst4_n         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.in_nbytes  = '0;
    bus.blk_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.in_last   = 1'b0;
    bus4.in_nbytes = '0;
    bus4.blk_ready = 1'b0;

    #12;
    checkOutput("reset_in_ready", bus.in_ready, 1'b0);
    checkOutput("reset_blk_valid", bus.blk_valid, 1'b0);
    checkOutput("reset_blk_data", bus.blk_data, '0);
    checkOutput("reset_blk_first", bus.blk_first, 1'b0);
    checkOutput("reset_blk_last", bus.blk_last, 1'b0);
    checkOutput("reset_len_err", bus.len_err, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_release", bus.in_ready, 1'b1);

    $display("[TB] abc message");
    msg = {8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 0);

    $display("[TB] empty message");
    msg.delete();
    applyStimulus(msg, 1);

    $display("[TB] 56-byte message");
    randomMsg(56);
    applyStimulus(msg, 0);

    $display("[TB] 64-byte message with 10-cycle stall");
    randomMsg(64);
    applyStimulus(msg, 10);

    $display("[TB] reset after 7 words");
    w      = 0;
    budget = 0;
    while (w < 7 && budget < 100) begin
      @(negedge clk);
      budget++;
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'b0;
      if (bus.in_ready) w++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("partial_words", w, 7);
    rst_n = 1'b0;
    #2;
    checkOutput("midmsg_reset_in_ready", bus.in_ready, 1'b0);
    checkOutput("midmsg_reset_blk_valid", bus.blk_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midmsg_in_ready_after_release", bus.in_ready, 1'b1);
    msg = {8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 2);

    $display("[TB] boundary lengths");
    foreach (lens[i]) begin
      randomMsg(lens[i]);
      applyStimulus(msg, $urandom_range(0, 3));
    end

    $display("[TB] random lengths");
    for (int r = 0; r < 12; r++) begin
      randomMsg($urandom_range(0, 140));
      applyStimulus(msg, $urandom_range(0, 3));
    end
    checkOutput("len_err_main", bus.len_err, 1'b0);

    $display("[TB] LEN_W=4 overflow");
    checkOutput("len4_initial", bus4.len_err, 1'b0);
    w      = 0;
    budget = 0;
    while (w < 4 && budget < 100) begin
      @(negedge clk);
      budget++;
      bus4.in_valid  = 1'b1;
      bus4.in_data   = $urandom;
      bus4.in_last   = (w == 3);
      bus4.in_nbytes = 3'd4;
      bus4.blk_ready = 1'b1;
      if (bus4.in_ready) w++;
    end
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    checkOutput("len4_words", w, 4);
    checkOutput("len4_err_set", bus4.len_err, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("len4_err_sticky", bus4.len_err, 1'b1);
    checkOutput("len4_idle", bus4.blk_valid, 1'b0);
    rst4_n = 1'b0;
    #1;
    checkOutput("len4_err_cleared", bus4.len_err, 1'b0);
    @(negedge clk);
    rst4_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 61, meaning the width of the message byte counter (maximum message length 2^LEN_W-1 bytes).
REQ-002 SHALL have port wb_clk_i  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  an input word is offered.
REQ-005 SHALL have port in_ready  output  1  the padder accepts the word this cycle.
REQ-006 SHALL have port in_data  input  32  message word, big-endian (first byte in [31:24]).
REQ-007 SHALL have port in_last  input  1  this word is the last word of the message.
REQ-008 SHALL have port in_nbytes  input  3  valid bytes in the last word, 0..4, left-aligned; ignored unless in_last.
REQ-009 SHALL have port blk_valid  output  1  a padded 512-bit block is presented.
REQ-010 SHALL have port blk_ready  input  1  the downstream SHA256 core takes the block.
REQ-011 SHALL have port blk_data  output  512  words 0..15, word0 in [511:480].
REQ-012 SHALL have port blk_first  output  1  the block is the first block of a message (downstream loads the IV).
REQ-013 SHALL have port blk_last  output  1  the block is the final block of a message (downstream reports the digest).
REQ-014 SHALL have port len_err  output  1  sticky flag: the byte counter overflowed LEN_W bits.

Function
REQ-015 SHALL implement FSM states ACCUM, PAD, LEN and EMIT, with a 16x32 buffer, a 4-bit word index idx, a LEN_W-bit byte counter and a first-block flag.
REQ-016 SHALL drive in_ready=1 only in ACCUM, so a handshake is in_valid&&in_ready.
REQ-017 On a non-last accept, SHALL write buf[idx]=in_data, add 4 to the counter and increment idx; at idx==15 it SHALL go to EMIT, returning to ACCUM.
REQ-018 On a last accept with in_nbytes=n<4, SHALL write buf[idx] with bytes 0..n-1 from in_data, byte n=0x80 and the remaining bytes 0, then add n and go to PAD with the marker flagged as placed.
REQ-019 On a last accept with n=4, SHALL write the word unchanged, add 4 and go to PAD with the marker flagged as pending.
REQ-020 For a full block (idx==15 on a last accept), SHALL first go to EMIT (blk_last=0), then continue in PAD at idx=0.
REQ-021 PAD SHALL write one word per cycle: 0x80000000 if the marker is pending, otherwise 0; it SHALL advance idx.
REQ-022 PAD SHALL go to LEN when the next index is 14.
REQ-023 If the marker lands at index 14 or 15, PAD SHALL zero-fill through 15, go to EMIT (blk_last=0), and repeat PAD from idx=0 in the next block.
REQ-024 LEN SHALL write {3'b0,counter} left-shifted by 3 (the bit length, 64 bits) into words 14 (high) and 15 (low) over 2 cycles, then go to EMIT with blk_last=1.
REQ-025 EMIT SHALL hold blk_valid=1 with blk_data/blk_first/blk_last stable until blk_ready.
REQ-026 On the EMIT handshake, SHALL clear blk_valid and go to the recorded next state.
REQ-027 After blk_last, the handshake SHALL clear the counter and idx, set the first-block flag and return to ACCUM.
REQ-028 blk_first SHALL be 1 on the first emitted block after reset or after a blk_last block, and 0 otherwise.
REQ-029 in_nbytes=0 with in_last SHALL contribute no bytes and SHALL place 0x80000000 at buf[idx] (empty message supported).
REQ-030 Words written in ACCUM/PAD SHALL overwrite stale buffer contents; no word of an emitted block SHALL hold data from a previous block.
REQ-031 A counter carry out of LEN_W bits SHALL set len_err (the counter wraps); len_err SHALL clear only on reset.
REQ-032 in_nbytes values 5..7 SHALL be treated as 4.

Reset
REQ-033 While wb_rst_ni=0, SHALL asynchronously force ACCUM, idx=0, counter=0 and the first-block flag set.
REQ-034 During reset, SHALL force in_ready=0, blk_valid=0, blk_data=0, blk_first=0, blk_last=0 and len_err=0.
REQ-035 Reset asserted mid-message or mid-EMIT SHALL discard the partial block; after release, in_ready=1 on the first clock edge.

Verification
REQ-036 "abc": one beat 0x61626300, last, nbytes=3 -> single block: w0=0x61626380, w1..w14=0, w15=0x00000018; first=last=1.
REQ-037 Empty message: last, nbytes=0 -> w0=0x80000000, all other words 0; first=last=1.
REQ-038 56-byte message (14 words, last nbytes=4) -> block1 w14=0x80000000, w15=0, last=0; block2 w0..w13=0, w14=0, w15=0x000001C0, first=0, last=1.
REQ-039 64-byte message, blk_ready held low 10 cycles -> block1 stays stable with in_ready=0; block2 w0=0x80000000, w15=0x00000200.
REQ-040 Reset pulsed after 7 accepted words, then "abc" -> output identical to REQ-036 with blk_first=1.
REQ-041 LEN_W=4 build, 16 bytes -> len_err=1 and remains set until reset.
